bcd_to_bin64: RTL and testbench



---
 rtl/misc_pkg.sv | 67 ++++++
 rtl/bcd_to_bin64_if.sv | 26 ++
 rtl/bcd_digit_mac.sv | 15 +
 rtl/bcd_to_bin64.sv | 168 ++++++++++++++++
 tb/tb_bcd_to_bin64.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/misc_pkg.sv
// Shared types and helpers for the packed-BCD to binary decoder (bcd_to_bin64).
// Honours BCD2BIN_DUAL_DIGIT_EN for the per-size start count of the digit counter.
package misc_pkg;

  localparam int unsigned W          = 64;
  localparam int unsigned DIGITS_MAX = W / 4;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    SZ8  = 2'd0,
    SZ16 = 2'd1,
    SZ32 = 2'd2,
    SZ64 = 2'd3
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [4:0] digits_of(input size_e sz);
    logic [4:0] n;
    case (sz)
      SZ8:     n = 5'd2;
      SZ16:    n = 5'd4;
      SZ32:    n = 5'd8;
      SZ64:    n = 5'd16;
      default: n = 5'd2;
    endcase
    return n;
  endfunction

  // Left shift that puts the most significant selected digit into [63:60].
  function automatic logic [5:0] align_shift_of(input size_e sz);
    logic [5:0] sh;
    case (sz)
      SZ8:     sh = 6'd56;
      SZ16:    sh = 6'd48;
      SZ32:    sh = 6'd32;
      SZ64:    sh = 6'd0;
      default: sh = 6'd0;
    endcase
    return sh;
  endfunction

  // Counter preload: number of RUN cycles minus one.
  function automatic logic [3:0] cnt_init_of(input size_e sz);
    logic [3:0] c;
    case (sz)
`ifdef BCD2BIN_DUAL_DIGIT_EN
      SZ8:     c = 4'd0;
      SZ16:    c = 4'd1;
      SZ32:    c = 4'd3;
      SZ64:    c = 4'd7;
`else
      SZ8:     c = 4'd1;
      SZ16:    c = 4'd3;
      SZ32:    c = 4'd7;
      SZ64:    c = 4'd15;
`endif
      default: c = 4'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bcd_to_bin64_if.sv
// Dispatch/writeback bus of the BCD decoder: operand, size, tag in; result, flags, RDY out.
interface bcd_to_bin64_if;
  import misc_pkg::*;

  logic             ACT;
  logic [1:0]       SA;
  logic [4:0]       DSTi;
  logic [W-1:0]     A;
  logic             BUSY;
  logic             RDY;
  logic [4:0]       DSTo;
  logic [W-1:0]     R;
  logic             ZERO;
  logic             INV;

  modport master (
    output ACT, SA, DSTi, A,
    input  BUSY, RDY, DSTo, R, ZERO, INV
  );

  modport slave (
    input  ACT, SA, DSTi, A,
    output BUSY, RDY, DSTo, R, ZERO, INV
  );

endinterface

// File: rtl/bcd_digit_mac.sv
// Combinational decimal multiply-accumulate step: acc*10 + digit, flagging digits above 9.
module bcd_digit_mac
  import misc_pkg::*;
(
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  output logic [W-1:0] sum,
  output logic         invalid
);

  // Invalid digits are still weighted by their raw value so the result stays deterministic.
  assign sum     = (acc << 3'd3) + (acc << 3'd1) + {{(W-4){1'b0}}, digit};
  assign invalid = (digit > BCD_DIGIT_MAX);

endmodule

// File: rtl/bcd_to_bin64.sv
// Iterative packed-BCD (2/4/8/16 digits) to binary decoder with ZERO/INV flags.
// Define BCD2BIN_DUAL_DIGIT_EN to consume two digits per RUN cycle.
module bcd_to_bin64
  import misc_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  bcd_to_bin64_if.slave bus
);

  state_e       state_r;
  state_e       next_state_s;
  logic [W-1:0] shreg_r;
  logic [W-1:0] acc_r;
  logic [3:0]   cnt_r;
  logic         inv_acc_r;
  logic [4:0]   tag_r;
  logic         busy_r;
  logic         rdy_r;
  logic [4:0]   dsto_r;
  logic [W-1:0] r_r;
  logic         zero_r;
  logic         inv_r;

  logic         accepting_s;
  logic         start_s;
  logic         step_s;
  logic         last_s;
  logic [W-1:0] new_acc_s;
  logic         digit_inv_s;
  size_e        size_s;

  assign size_s = size_e'(bus.SA);

`ifdef BCD2BIN_DUAL_DIGIT_EN
  localparam int unsigned STEP_BITS = 8;

  logic [W-1:0] mid_acc_s;
  logic         inv_hi_s;
  logic         inv_lo_s;

  bcd_digit_mac u_mac_hi (
    .acc     (acc_r),
    .digit   (shreg_r[63:60]),
    .sum     (mid_acc_s),
    .invalid (inv_hi_s)
  );

  bcd_digit_mac u_mac_lo (
    .acc     (mid_acc_s),
    .digit   (shreg_r[59:56]),
    .sum     (new_acc_s),
    .invalid (inv_lo_s)
  );

  assign digit_inv_s = inv_hi_s | inv_lo_s;
`else
  localparam int unsigned STEP_BITS = 4;

  bcd_digit_mac u_mac (
    .acc     (acc_r),
    .digit   (shreg_r[63:60]),
    .sum     (new_acc_s),
    .invalid (digit_inv_s)
  );
`endif

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RUN;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    accepting_s = (state_r == IDLE) || rdy_r;
    start_s     = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        start_s = bus.ACT && accepting_s;
      end
      RUN: begin
        step_s = 1'b1;
        last_s = (cnt_r == 4'd0);
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs; ACT during RUN is simply not sampled.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shreg_r   <= {W{1'b0}};
      acc_r     <= {W{1'b0}};
      cnt_r     <= 4'd0;
      inv_acc_r <= 1'b0;
      tag_r     <= 5'd0;
      busy_r    <= 1'b0;
      rdy_r     <= 1'b0;
      dsto_r    <= 5'd0;
      r_r       <= {W{1'b0}};
      zero_r    <= 1'b0;
      inv_r     <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      if (start_s) begin
        shreg_r   <= bus.A << align_shift_of(size_s);
        tag_r     <= bus.DSTi;
        cnt_r     <= cnt_init_of(size_s);
        acc_r     <= {W{1'b0}};
        inv_acc_r <= 1'b0;
        busy_r    <= 1'b1;
      end else if (step_s) begin
        acc_r     <= new_acc_s;
        shreg_r   <= shreg_r << STEP_BITS;
        inv_acc_r <= inv_acc_r | digit_inv_s;
        if (last_s) begin
          cnt_r  <= 4'd0;
          r_r    <= new_acc_s;
          zero_r <= (new_acc_s == {W{1'b0}});
          inv_r  <= inv_acc_r | digit_inv_s;
          dsto_r <= tag_r;
          rdy_r  <= 1'b1;
          busy_r <= 1'b0;
        end else begin
          cnt_r <= cnt_r - 4'd1;
        end
      end
    end
  end

  assign bus.BUSY = busy_r;
  assign bus.RDY  = rdy_r;
  assign bus.DSTo = dsto_r;
  assign bus.R    = r_r;
  assign bus.ZERO = zero_r;
  assign bus.INV  = inv_r;

endmodule

// File: tb/tb_bcd_to_bin64.sv
// Directed self-checking bench for bcd_to_bin64; expected latencies follow BCD2BIN_DUAL_DIGIT_EN.
module tb_bcd_to_bin64;

  logic CLK = 1'b0;
  logic RESET;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  bcd_to_bin64_if bus_if ();

  bcd_to_bin64 dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] sa);
`ifdef BCD2BIN_DUAL_DIGIT_EN
    return 1 << sa;
`else
    return 2 << sa;
`endif
  endfunction

  // Present one ACT for a single edge; returns at #1 after that edge.
  task automatic start(input logic [1:0] sa, input logic [63:0] a, input logic [4:0] tag);
    @(negedge CLK);
    bus_if.ACT  = 1'b1;
    bus_if.SA   = sa;
    bus_if.A    = a;
    bus_if.DSTi = tag;
    @(posedge CLK);
    #1;
    bus_if.ACT = 1'b0;
  endtask

  // Count edges until RDY, bounded; returns at #1 after the RDY edge.
  task automatic wait_rdy(input string tag, input int exp_lat);
    int lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK);
      #1;
      if (bus_if.RDY === 1'b1) begin
        lat = k;
        break;
      end
    end
    check(tag, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_seen;
    RESET       = 1'b1;
    bus_if.ACT  = 1'b0;
    bus_if.SA   = 2'd0;
    bus_if.A    = 64'd0;
    bus_if.DSTi = 5'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", {63'd0, bus_if.BUSY}, 64'd0);
    check("rst_rdy", {63'd0, bus_if.RDY}, 64'd0);
    check("rst_dsto_zero_inv", {57'd0, bus_if.DSTo, bus_if.ZERO, bus_if.INV}, 64'd0);
    check("rst_r", bus_if.R, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // 2 digits: 42 -> 0x2A
    start(2'd0, 64'h42, 5'd5);
    check("s1_busy", {63'd0, bus_if.BUSY}, 64'd1);
    check("s1_rdy_early", {63'd0, bus_if.RDY}, 64'd0);
    wait_rdy("s1_lat", lat_of(2'd0));
    check("s1_r", bus_if.R, 64'h2A);
    check("s1_flags", {62'd0, bus_if.ZERO, bus_if.INV}, 64'd0);
    check("s1_dsto", {59'd0, bus_if.DSTo}, 64'd5);
    check("s1_busy_done", {63'd0, bus_if.BUSY}, 64'd0);
    @(posedge CLK);
    #1;
    check("s1_rdy_pulse", {63'd0, bus_if.RDY}, 64'd0);
    check("s1_r_hold", bus_if.R, 64'h2A);

    // 16 nines -> 10^16 - 1
    start(2'd3, 64'h9999_9999_9999_9999, 5'd17);
    wait_rdy("s2_lat", lat_of(2'd3));
    check("s2_r", bus_if.R, 64'h0023_86F2_6FC0_FFFF);
    check("s2_inv", {63'd0, bus_if.INV}, 64'd0);
    check("s2_dsto", {59'd0, bus_if.DSTo}, 64'd17);

    // 4 digits with an invalid 0xA, upper bits ignored: 1*1000+2*100+10*10+4
    start(2'd1, 64'hFFFF_12A4, 5'd1);
    wait_rdy("s3_lat", lat_of(2'd1));
    check("s3_r", bus_if.R, 64'h518);
    check("s3_inv", {63'd0, bus_if.INV}, 64'd1);
    check("s3_zero", {63'd0, bus_if.ZERO}, 64'd0);

    // Zero operand, plus an ACT while busy that must be ignored
    start(2'd2, 64'd0, 5'd3);
    @(negedge CLK);
    bus_if.ACT  = 1'b1;
    bus_if.SA   = 2'd0;
    bus_if.A    = 64'h99;
    bus_if.DSTi = 5'd7;
    @(posedge CLK);
    #1;
    bus_if.ACT = 1'b0;
    wait_rdy("s4_lat", lat_of(2'd2) - 1);
    check("s4_r", bus_if.R, 64'd0);
    check("s4_zero", {63'd0, bus_if.ZERO}, 64'd1);
    check("s4_inv", {63'd0, bus_if.INV}, 64'd0);
    check("s4_dsto", {59'd0, bus_if.DSTo}, 64'd3);

    // ACT in the RDY cycle starts the next conversion
    bus_if.ACT  = 1'b1;
    bus_if.SA   = 2'd0;
    bus_if.A    = 64'h07;
    bus_if.DSTi = 5'd9;
    @(posedge CLK);
    #1;
    bus_if.ACT = 1'b0;
    check("s5_busy", {63'd0, bus_if.BUSY}, 64'd1);
    wait_rdy("s5_lat", lat_of(2'd0));
    check("s5_r", bus_if.R, 64'd7);
    check("s5_dsto", {59'd0, bus_if.DSTo}, 64'd9);
    check("s5_zero", {63'd0, bus_if.ZERO}, 64'd0);

    // Reset mid-conversion
    start(2'd3, 64'h1234, 5'd12);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check("s6_busy", {63'd0, bus_if.BUSY}, 64'd0);
    check("s6_r", bus_if.R, 64'd0);
    check("s6_dsto_flags", {57'd0, bus_if.DSTo, bus_if.ZERO, bus_if.INV}, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    rdy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK);
      #1;
      if (bus_if.RDY === 1'b1) rdy_seen++;
    end
    check("s6_no_rdy", 64'(rdy_seen), 64'd0);

    start(2'd3, 64'h1234, 5'd12);
    wait_rdy("s7_lat", lat_of(2'd3));
    check("s7_r", bus_if.R, 64'h4D2);
    check("s7_dsto", {59'd0, bus_if.DSTo}, 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
